// File: rtl/vx_smem_bank_sched_pkg.sv
// Shared types and helpers for the shared-memory bank scheduler: FSM state
// encoding and lane/bank index width helpers.
package vx_smem_bank_sched_pkg;

  localparam int SMEM_NUM_REQS  = 4;
  localparam int SMEM_NUM_BANKS = 4;
  localparam int SMEM_ADDRW     = 30;
  localparam int SMEM_DATAW     = 32;
  localparam int SMEM_TAGW      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RSP   = 2'd3
  } state_e;

  // A lane index needs at least one bit even for a single-lane build.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_smem_bank_sched_if.sv
// Core-side batch request/response plus bank-array strobes of the shared-memory
// bank scheduler; master is the surrounding core/SRAM side, slave is the scheduler.
interface vx_smem_bank_sched_if #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int ADDRW     = 30,
  parameter int DATAW     = 32,
  parameter int TAGW      = 8
);
  logic                                       req_valid;
  logic [NUM_REQS-1:0]                        req_tmask;
  logic                                       req_rw;
  logic [NUM_REQS*ADDRW-1:0]                  req_addr;
  logic [NUM_REQS*DATAW/8-1:0]                req_byteen;
  logic [NUM_REQS*DATAW-1:0]                  req_data;
  logic [TAGW-1:0]                            req_tag;
  logic                                       req_ready;

  logic [NUM_BANKS-1:0]                       bank_req_valid;
  logic [NUM_BANKS-1:0]                       bank_req_rw;
  logic [NUM_BANKS*(ADDRW-$clog2(NUM_BANKS))-1:0] bank_req_addr;
  logic [NUM_BANKS*DATAW/8-1:0]               bank_req_byteen;
  logic [NUM_BANKS*DATAW-1:0]                 bank_req_data;
  logic [NUM_BANKS*DATAW-1:0]                 bank_rsp_data;

  logic                                       rsp_valid;
  logic [NUM_REQS-1:0]                        rsp_tmask;
  logic [NUM_REQS*DATAW-1:0]                  rsp_data;
  logic [TAGW-1:0]                            rsp_tag;
  logic                                       rsp_ready;

  modport master (
    output req_valid, req_tmask, req_rw, req_addr, req_byteen, req_data, req_tag,
    input  req_ready,
    input  bank_req_valid, bank_req_rw, bank_req_addr, bank_req_byteen, bank_req_data,
    output bank_rsp_data,
    input  rsp_valid, rsp_tmask, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_tmask, req_rw, req_addr, req_byteen, req_data, req_tag,
    output req_ready,
    output bank_req_valid, bank_req_rw, bank_req_addr, bank_req_byteen, bank_req_data,
    input  bank_rsp_data,
    output rsp_valid, rsp_tmask, rsp_data, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/vx_smem_bank_sched_pick.sv
// Per-bank selector: lowest pending lane mapped to BANK_ID wins the bank;
// reads also serve every pending lane sharing the winner's full address.
module vx_smem_bank_sched_pick
  import vx_smem_bank_sched_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int ADDRW     = 30,
  parameter int BANK_ID   = 0
) (
  input  logic [NUM_REQS-1:0]           pending,
  input  logic [$clog2(NUM_BANKS)-1:0]  lane_bank [NUM_REQS],
  input  logic [ADDRW-1:0]              lane_addr [NUM_REQS],
  input  logic                          rw,
  output logic [lane_bits(NUM_REQS)-1:0] winner,
  output logic [NUM_REQS-1:0]           serve_mask,
  output logic                          valid
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int LANEW     = lane_bits(NUM_REQS);

  logic [NUM_REQS-1:0] cand_s;

  // Candidate lanes, priority winner and serve mask for this bank.
  always_comb begin
    cand_s     = '0;
    winner     = '0;
    serve_mask = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand_s[i] = pending[i] && (lane_bank[i] == BANK_BITS'(BANK_ID));
    end
    // Scan downwards so the lowest candidate is the last one written.
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      winner = cand_s[i] ? LANEW'(i) : winner;
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      serve_mask[i] = cand_s[i] &&
                      (rw ? (LANEW'(i) == winner) : (lane_addr[i] == lane_addr[winner]));
    end
    valid = |cand_s;
  end

endmodule

// File: rtl/vx_smem_bank_sched.sv
// Shared-memory bank scheduler: accepts one warp batch, serialises bank
// conflicts over ISSUE cycles, gathers read data and returns one response.
module vx_smem_bank_sched
  import vx_smem_bank_sched_pkg::*;
#(
  parameter int NUM_REQS  = SMEM_NUM_REQS,
  parameter int NUM_BANKS = SMEM_NUM_BANKS,
  parameter int ADDRW     = SMEM_ADDRW,
  parameter int DATAW     = SMEM_DATAW,
  parameter int TAGW      = SMEM_TAGW
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_smem_bank_sched_if.slave  bus
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROWW      = ADDRW - BANK_BITS;
  localparam int BYTEW     = DATAW / 8;
  localparam int LANEW     = lane_bits(NUM_REQS);

  state_e                state_q, state_d;
  logic [NUM_REQS-1:0]   pending_q, pending_d;
  logic [NUM_REQS-1:0]   tmask_q, tmask_d;
  logic [NUM_REQS-1:0]   served_q, served_d;
  logic                  rw_q, rw_d;
  logic [TAGW-1:0]       tag_q, tag_d;
  logic [ADDRW-1:0]      addr_q   [NUM_REQS];
  logic [ADDRW-1:0]      addr_d   [NUM_REQS];
  logic [BYTEW-1:0]      byteen_q [NUM_REQS];
  logic [BYTEW-1:0]      byteen_d [NUM_REQS];
  logic [DATAW-1:0]      wdata_q  [NUM_REQS];
  logic [DATAW-1:0]      wdata_d  [NUM_REQS];
  logic [DATAW-1:0]      rdata_q  [NUM_REQS];
  logic [DATAW-1:0]      rdata_d  [NUM_REQS];

  logic [BANK_BITS-1:0]  lane_bank_s  [NUM_REQS];
  logic [LANEW-1:0]      winner_s     [NUM_BANKS];
  logic [NUM_REQS-1:0]   serve_s      [NUM_BANKS];
  logic [DATAW-1:0]      bank_rdata_s [NUM_BANKS];
  logic [NUM_BANKS-1:0]  hit_s;
  logic [NUM_REQS-1:0]   served_now_s;

  logic [NUM_BANKS-1:0]       bank_valid_s;
  logic [NUM_BANKS-1:0]       bank_rw_s;
  logic [NUM_BANKS*ROWW-1:0]  bank_addr_s;
  logic [NUM_BANKS*BYTEW-1:0] bank_byteen_s;
  logic [NUM_BANKS*DATAW-1:0] bank_data_s;
  logic [NUM_REQS*DATAW-1:0]  rsp_data_s;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    assign lane_bank_s[i] = addr_q[i][BANK_BITS-1:0];
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vx_smem_bank_sched_pick #(
      .NUM_REQS  (NUM_REQS),
      .NUM_BANKS (NUM_BANKS),
      .ADDRW     (ADDRW),
      .BANK_ID   (b)
    ) u_pick (
      .pending    (pending_q),
      .lane_bank  (lane_bank_s),
      .lane_addr  (addr_q),
      .rw         (rw_q),
      .winner     (winner_s[b]),
      .serve_mask (serve_s[b]),
      .valid      (hit_s[b])
    );
    assign bank_rdata_s[b] = bus.bank_rsp_data[b*DATAW +: DATAW];
  end

  // Bank strobes come straight from registered state; idle banks drive zeros.
  always_comb begin
    bank_valid_s  = '0;
    bank_rw_s     = '0;
    bank_addr_s   = '0;
    bank_byteen_s = '0;
    bank_data_s   = '0;
    served_now_s  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_valid_s[b] = (state_q == ST_ISSUE) && hit_s[b];
      bank_rw_s[b]    = bank_valid_s[b] && rw_q;
      bank_addr_s[b*ROWW +: ROWW] =
        bank_valid_s[b] ? addr_q[winner_s[b]][ADDRW-1:BANK_BITS] : {ROWW{1'b0}};
      bank_byteen_s[b*BYTEW +: BYTEW] =
        bank_valid_s[b] ? byteen_q[winner_s[b]] : {BYTEW{1'b0}};
      bank_data_s[b*DATAW +: DATAW] =
        bank_valid_s[b] ? wdata_q[winner_s[b]] : {DATAW{1'b0}};
      served_now_s = served_now_s | (bank_valid_s[b] ? serve_s[b] : {NUM_REQS{1'b0}});
    end
  end

  // Next-state, batch latch and read-data capture.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tmask_d   = tmask_q;
    served_d  = '0;
    rw_d      = rw_q;
    tag_d     = tag_q;
    addr_d    = addr_q;
    byteen_d  = byteen_q;
    wdata_d   = wdata_q;
    // Lanes strobed last cycle pick up their bank's read data now.
    for (int i = 0; i < NUM_REQS; i++) begin
      rdata_d[i] = served_q[i] ? bank_rdata_s[lane_bank_s[i]] : rdata_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          pending_d = bus.req_tmask;
          tmask_d   = bus.req_tmask;
          rw_d      = bus.req_rw;
          tag_d     = bus.req_tag;
          for (int i = 0; i < NUM_REQS; i++) begin
            addr_d[i]   = bus.req_addr[i*ADDRW +: ADDRW];
            byteen_d[i] = bus.req_byteen[i*BYTEW +: BYTEW];
            wdata_d[i]  = bus.req_data[i*DATAW +: DATAW];
            rdata_d[i]  = {DATAW{1'b0}};
          end
          state_d = (bus.req_tmask != '0) ? ST_ISSUE : ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        pending_d = pending_q & ~served_now_s;
        served_d  = rw_q ? {NUM_REQS{1'b0}} : served_now_s;
        if (pending_d == '0) begin
          state_d = rw_q ? ST_IDLE : ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      tmask_q   <= '0;
      served_q  <= '0;
      rw_q      <= 1'b0;
      tag_q     <= '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        addr_q[i]   <= '0;
        byteen_q[i] <= '0;
        wdata_q[i]  <= '0;
        rdata_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      tmask_q   <= tmask_d;
      served_q  <= served_d;
      rw_q      <= rw_d;
      tag_q     <= tag_d;
      addr_q    <= addr_d;
      byteen_q  <= byteen_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Pack per-lane response data onto the flat bus.
  always_comb begin
    rsp_data_s = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_data_s[i*DATAW +: DATAW] = rdata_q[i];
    end
  end

  assign bus.req_ready       = (state_q == ST_IDLE);
  assign bus.bank_req_valid  = bank_valid_s;
  assign bus.bank_req_rw     = bank_rw_s;
  assign bus.bank_req_addr   = bank_addr_s;
  assign bus.bank_req_byteen = bank_byteen_s;
  assign bus.bank_req_data   = bank_data_s;
  assign bus.rsp_valid       = (state_q == ST_RSP);
  assign bus.rsp_tmask       = tmask_q;
  assign bus.rsp_data        = rsp_data_s;
  assign bus.rsp_tag         = tag_q;

endmodule
